// File: rtl/ins_memory_pipe.sv
// Instruction memory with a one-cycle registered fetch port and a program-load write port.
// Define INS_MEMORY_CLEAR_EN to zero the whole array after every reset (busy high meanwhile).
`ifndef INS_START_ADDRESS
`define INS_START_ADDRESS 32'h0000_0000
`endif

module ins_memory_pipe #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = `INS_START_ADDRESS,
  parameter logic [DATA_W-1:0] NOP_WORD  = 32'h0000_0013
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] instruction,
  output logic              fetch_fault,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  clr_idx;
  logic              clr_we;
  logic              fetch_go, fetch_bad;
  logic              load_go, load_bad;

  // The below-base test is separate from the offset test so a PC under BASE_ADDR
  // cannot wrap into a small in-range offset, and a PC near the top cannot wrap back.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ((off >> 2) >= ADDR_W'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = (a - BASE_ADDR) >> 2;
    return off[IDX_W-1:0];
  endfunction

  assign fetch_ready = (state == IDLE) && !SYS_reset;
  assign fetch_go    = fetch_req && fetch_ready;
  assign fetch_bad   = addr_bad(fetch_pc);
  assign load_go     = load_we && fetch_ready;
  assign load_bad    = addr_bad(load_addr);

`ifdef INS_MEMORY_CLEAR_EN
  logic clr_last;

  assign clr_last = (clr_idx == IDX_W'(DEPTH - 1));
  assign clr_we   = (state == CLEAR);
  assign busy     = (state == CLEAR);

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_idx <= clr_last ? '0 : clr_idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if ((state == CLEAR) && clr_last) state_nxt = IDLE;
  end
`else
  assign clr_idx = '0;
  assign clr_we  = 1'b0;
  assign busy    = 1'b0;

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
  end
`endif

  // Array write port: clear sweep has priority; loads only reach here when idle.
  always_ff @(posedge SYS_clk) begin
    if (clr_we)                    mem[clr_idx]            <= '0;
    else if (load_go && !load_bad) mem[word_idx(load_addr)] <= load_data;
  end

  // Fetch result stage: old array contents are read, so a same-cycle load is not seen.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      load_err    <= 1'b0;
      instruction <= NOP_WORD;
    end else begin
      fetch_valid <= fetch_go;
      fetch_fault <= fetch_go && fetch_bad;
      load_err    <= load_go && load_bad;
      if (fetch_go) instruction <= fetch_bad ? NOP_WORD : mem[word_idx(fetch_pc)];
    end
  end

endmodule

// File: doc/ins_memory_pipe.md
INS_MEMORY_PIPE -- requirements
Module: ins_memory_pipe

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of fetch_pc and load_addr.
REQ-002 SHALL have parameter DATA_W, default 32, instruction word width; DATA_W=32 is the only supported value.
REQ-003 SHALL have parameter DEPTH, default 1024, number of words stored; DEPTH SHALL be at least 2.
REQ-004 SHALL have parameter BASE_ADDR, default `INS_START_ADDRESS, the byte address of word index 0.
REQ-005 SHALL have parameter NOP_WORD, default 32'h0000_0013, the word returned on a fault and at reset.
REQ-006 SYS_clk  in  1  the single clock; all logic is on its rising edge.
REQ-007 SYS_reset  in  1  reset, synchronous and active-high.
REQ-008 fetch_req  in  1  fetch request.
REQ-009 fetch_pc  in  ADDR_W  fetch byte address.
REQ-010 fetch_ready  out  1  high when a fetch is accepted this cycle.
REQ-011 fetch_valid  out  1  one-cycle pulse marking the fetch result.
REQ-012 instruction  out  DATA_W  registered fetch data.
REQ-013 fetch_fault  out  1  qualifies fetch_valid; high for a misaligned or out-of-range PC.
REQ-014 load_we  in  1  program-load write strobe.
REQ-015 load_addr  in  ADDR_W  program-load byte address.
REQ-016 load_data  in  DATA_W  program-load word.
REQ-017 load_err  out  1  one-cycle pulse when a load is rejected.
REQ-018 busy  out  1  high while the clear sequence runs.

Function
REQ-019 SHALL implement two states: CLEAR and IDLE; fetch_ready = (state==IDLE), and busy = (state==CLEAR).
REQ-020 In CLEAR, SHALL write 0 to word clr_idx each cycle, with clr_idx counting 0..DEPTH-1, then go to IDLE; CLEAR lasts exactly DEPTH cycles.
REQ-021 A fetch is accepted when fetch_req and fetch_ready are both high; fetch_valid SHALL be 1 in the next cycle only; latency is 1 cycle.
REQ-022 Word index SHALL be (fetch_pc - BASE_ADDR) >> 2, using ADDR_W-bit unsigned arithmetic.
REQ-023 Fault SHALL be raised when fetch_pc[1:0] != 0, when fetch_pc < BASE_ADDR, or when the index is >= DEPTH.
REQ-024 On a fault, the result SHALL be fetch_fault=1 and instruction=NOP_WORD, and the array SHALL NOT be read.
REQ-025 instruction SHALL hold its value until the next accepted fetch; fetch_fault SHALL be 0 whenever fetch_valid is 0.
REQ-026 A load in IDLE with an aligned, in-range load_addr SHALL write load_data at the end of that cycle.
REQ-027 A load in IDLE that is misaligned or out of range SHALL write nothing and SHALL pulse load_err in the next cycle.
REQ-028 load_we during CLEAR SHALL be ignored: no write and no load_err.
REQ-029 A fetch and a load to the same index in the same cycle SHALL return the old word (read-before-write).
REQ-030 Back-to-back fetches SHALL give one result per cycle, with fetch_valid held high continuously.
REQ-031 The address range check SHALL handle PCs near the top of the address space without wrap-around false hits (e.g. 0xFFFF_FFFC with BASE_ADDR=0).

Reset
REQ-032 While SYS_reset=1 at a rising edge, the block SHALL take these values: state=CLEAR (or IDLE, per REQ-036), clr_idx=0, fetch_valid=0, fetch_fault=0, load_err=0, instruction=NOP_WORD.
REQ-033 While reset is held, clr_idx SHALL stay 0 and no fetch or load SHALL be accepted.
REQ-034 Reset asserted mid-CLEAR or mid-fetch SHALL abort the operation: no fetch_valid for the in-flight fetch, and CLEAR restarts from index 0 after reset is released.

Configuration
REQ-035 With macro INS_MEMORY_CLEAR_EN defined, reset SHALL enter CLEAR as described in REQ-019 and REQ-020.
REQ-036 Without INS_MEMORY_CLEAR_EN, reset SHALL go directly to IDLE, busy SHALL be constant 0, and array contents SHALL survive reset.

Verification
REQ-037 Bench with DEPTH=16, BASE_ADDR=0x1000, INS_MEMORY_CLEAR_EN defined: release reset -> busy=1 for exactly 16 cycles, then fetch 0x1000 returns 0x00000000 with fetch_valid one cycle after request.
REQ-038 Load 0x00500093 at 0x1008, then fetch 0x1008 next cycle -> instruction=0x00500093, fetch_fault=0.
REQ-039 Fetch 0x1002, 0x0FFC and 0x1040 -> each gives fetch_valid=1, fetch_fault=1, instruction=0x00000013; load to 0x1040 -> load_err pulse and no write.
REQ-040 Same-cycle load 0xAAAA_AAAA and fetch at 0x1004 (old value 0x1111_1111) -> fetch returns 0x1111_1111; next fetch returns 0xAAAA_AAAA.
REQ-041 Assert reset at clear cycle 7 -> busy stays 1, and clear restarts for 16 full cycles after release; without INS_MEMORY_CLEAR_EN, data loaded before reset is still readable after reset.
